// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout reads take every 4th visible pixel slot, queued
// game-logic writes fill the remaining cycles. Video outputs are re-aligned to the 3-cycle read latency.
module vram_arbiter #(
  parameter int FB_W       = 160,
  parameter int FB_H       = 120,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  col,
  input  logic [9:0]  row,
  input  logic        valid,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [14:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic [14:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  rgb,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        frame_start,
  output logic        oob_err
);

  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam logic [15:0] FB_WORDS = 16'(FB_W * FB_H);

  logic [14:0] fifo_addr_mem [FIFO_DEPTH];
  logic [7:0]  fifo_data_mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr_reg;
  logic [PW:0] rd_ptr_reg;
  logic        fifo_empty;
  logic        fifo_full;
  logic        accept;
  logic        in_range;
  logic        push;
  logic        pop;
  logic        oob_hit;
  logic        slot;
  logic [14:0] slot_addr;
  logic [14:0] head_addr;
  logic [7:0]  head_data;
  logic        slot_d1_reg;
  logic        slot_d2_reg;
  logic [7:0]  pix_reg;
  logic [2:0]  dly3;

  assign slot      = valid && (col[1:0] == 2'b00);
  assign slot_addr = 15'(row[9:2]) * 15'(FB_W) + 15'(col[9:2]);

  assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
  assign fifo_full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                      (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);
  assign wr_ready   = !fifo_full;

  // Out-of-range writes complete the handshake but never occupy an entry.
  assign accept   = wr_valid && wr_ready;
  assign in_range = ({1'b0, wr_addr} < FB_WORDS);
  assign push     = accept && in_range;
  assign oob_hit  = accept && !in_range;
  assign pop      = !slot && !fifo_empty;

  assign head_addr = fifo_addr_mem[rd_ptr_reg[PW-1:0]];
  assign head_data = fifo_data_mem[rd_ptr_reg[PW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_mem[wr_ptr_reg[PW-1:0]] <= wr_addr;
      fifo_data_mem[wr_ptr_reg[PW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // Scanout has absolute priority; an idle cycle keeps the last address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else if (slot) begin
      mem_addr <= slot_addr;
      mem_we   <= 1'b0;
    end else if (pop) begin
      mem_addr  <= head_addr;
      mem_wdata <= head_data;
      mem_we    <= 1'b1;
    end else begin
      mem_we <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_d1_reg <= 1'b0;
      slot_d2_reg <= 1'b0;
      pix_reg     <= '0;
    end else begin
      slot_d1_reg <= slot;
      slot_d2_reg <= slot_d1_reg;
      if (slot_d2_reg) pix_reg <= mem_rdata;
    end
  end

  // Three-stage delay of {valid, hsync, vsync}; idle value is blank with syncs inactive.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dly
      logic [2:0] stage_reg;
      logic [2:0] stage_in;
      if (gi == 0) begin : g_src
        assign stage_in = {valid, hsync_in, vsync_in};
      end else begin : g_chain
        assign stage_in = g_dly[gi-1].stage_reg;
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stage_reg <= 3'b011;
        else        stage_reg <= stage_in;
      end
    end
  endgenerate

  assign dly3      = g_dly[2].stage_reg;
  assign rgb       = dly3[2] ? pix_reg : 8'h00;
  assign hsync_out = dly3[1];
  assign vsync_out = dly3[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_start <= 1'b0;
      oob_err     <= 1'b0;
    end else begin
      frame_start <= (col == 10'd0) && (row == 10'd0);
      if (oob_hit)          oob_err <= 1'b1;
      else if (frame_start) oob_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: scanout timing, write contention, full queue,
// out-of-range drops, sync alignment and mid-frame reset.
module tb_vram_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  col;
  logic [9:0]  row;
  logic        valid;
  logic        hsync_in;
  logic        vsync_in;
  logic        wr_valid;
  logic        wr_ready;
  logic [14:0] wr_addr;
  logic [7:0]  wr_data;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic [7:0]  rgb;
  logic        hsync_out;
  logic        vsync_out;
  logic        frame_start;
  logic        oob_err;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [14:0] a;
    logic [7:0]  d;
  } wr_t;
  wr_t log_q[$];

  vram_arbiter dut (
    .clk(clk), .rst_n(rst_n), .col(col), .row(row), .valid(valid),
    .hsync_in(hsync_in), .vsync_in(vsync_in),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out),
    .frame_start(frame_start), .oob_err(oob_err)
  );

  always #5 clk = ~clk;

  // VRAM model: read data is the low byte of the address, one cycle late.
  always @(posedge clk) mem_rdata <= mem_addr[7:0];

  always @(posedge clk) begin
    if (mem_we) log_q.push_back(wr_t'{mem_addr, mem_wdata});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic px(input int c, input int r, input logic v);
    col   = 10'(c);
    row   = 10'(r);
    valid = v;
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    px(700, 500, 1'b0);
    hsync_in = 1'b1; vsync_in = 1'b1;
    wr_valid = 1'b0; wr_addr = '0; wr_data = '0;
    repeat (3) tick();

    check("rst_ready", wr_ready, 1);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wdata", mem_wdata, 0);
    check("rst_rgb", rgb, 0);
    check("rst_hs", hsync_out, 1);
    check("rst_vs", vsync_out, 1);
    check("rst_fs", frame_start, 0);
    check("rst_oob", oob_err, 0);

    rst_n = 1'b1;
    tick();

    // Scanout immediately after reset release
    for (int k = 0; k < 8; k++) begin
      px(12 + k, 8, 1'b1);
      if (k == 1) begin
        check("scan_addr", mem_addr, 323);
        check("scan_we", mem_we, 0);
      end
      if (k >= 3 && k <= 6) check("scan_rgb", rgb, 8'h43);
      if (k == 7) check("scan_rgb_next", rgb, 8'h44);
      tick();
    end
    px(700, 500, 1'b0);
    repeat (4) tick();
    check("scan_blank_rgb", rgb, 0);

    // Write contention with a scanout slot
    px(4, 4, 1'b1); wr_valid = 1'b1; wr_addr = 15'd5; wr_data = 8'hAA;
    check("cont_ready", wr_ready, 1);
    tick();
    wr_valid = 1'b0; px(5, 4, 1'b1);
    check("cont_we_t1", mem_we, 0);
    check("cont_addr_t1", mem_addr, 161);
    tick();
    px(6, 4, 1'b1);
    check("cont_we_t2", mem_we, 1);
    check("cont_addr_t2", mem_addr, 5);
    check("cont_data_t2", mem_wdata, 8'hAA);
    tick();
    px(700, 500, 1'b0);
    check("cont_we_t3", mem_we, 0);
    repeat (3) tick();

    // Full queue: every cycle a scanout slot so nothing drains
    log_q.delete();
    for (int i = 0; i < 4; i++) begin
      px(4 * i, 12, 1'b1);
      wr_valid = 1'b1; wr_addr = 15'(100 + i); wr_data = 8'(16 + i);
      check("full_ready_pre", wr_ready, 1);
      tick();
    end
    px(16, 12, 1'b1); wr_addr = 15'd104; wr_data = 8'h14;
    check("full_ready_blk", wr_ready, 0);
    check("full_we_blk", mem_we, 0);
    tick();
    px(17, 12, 1'b1);
    check("full_ready_pop", wr_ready, 0);
    tick();
    px(18, 12, 1'b1);
    check("full_ready_free", wr_ready, 1);
    tick();
    wr_valid = 1'b0; px(700, 500, 1'b0);
    repeat (8) tick();
    check("full_cnt", log_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      if (i < log_q.size()) begin
        check("full_order_addr", log_q[i].a, 100 + i);
        check("full_order_data", log_q[i].d, 16 + i);
      end
    end

    // Address range edge and out-of-range drop
    log_q.delete();
    px(700, 300, 1'b0); wr_valid = 1'b1; wr_addr = 15'd19199; wr_data = 8'h77;
    check("edge_ready", wr_ready, 1);
    tick();
    wr_addr = 15'd19200; wr_data = 8'h55;
    check("edge_oob", oob_err, 0);
    tick();
    wr_valid = 1'b0;
    check("edge_we", mem_we, 1);
    check("edge_addr", mem_addr, 19199);
    check("oob_flag", oob_err, 1);
    tick();
    check("oob_we", mem_we, 0);
    repeat (3) tick();
    check("oob_cnt", log_q.size(), 1);
    check("oob_hold", oob_err, 1);

    px(0, 0, 1'b1); tick();
    px(1, 0, 1'b1);
    check("fs_pulse", frame_start, 1);
    tick();
    px(2, 0, 1'b1);
    check("fs_done", frame_start, 0);
    check("oob_clear", oob_err, 0);
    tick();

    // Out-of-range accept during the frame_start cycle keeps the flag set
    px(0, 0, 1'b1); tick();
    px(1, 0, 1'b1); wr_valid = 1'b1; wr_addr = 15'd20000;
    check("fs_pulse2", frame_start, 1);
    tick();
    wr_valid = 1'b0; px(2, 0, 1'b1);
    check("oob_setwins", oob_err, 1);
    tick();
    px(700, 500, 1'b0);
    repeat (4) tick();

    // Sync alignment through blanking
    for (int c = 650; c < 664; c++) begin
      px(c, 480, 1'b0);
      hsync_in = (c >= 656) ? 1'b0 : 1'b1;
      vsync_in = (c == 658) ? 1'b0 : 1'b1;
      if (c == 658) check("hs_t2", hsync_out, 1);
      if (c == 659) check("hs_t3", hsync_out, 0);
      if (c == 661) check("vs_t3", vsync_out, 0);
      if (c == 662) check("vs_t4", vsync_out, 1);
      if (c % 4 == 0) check("blank_rgb", rgb, 0);
      tick();
    end
    hsync_in = 1'b1; vsync_in = 1'b1;
    repeat (3) tick();

    // Mid-frame reset with three writes queued behind scanout slots
    for (int i = 0; i < 3; i++) begin
      px(20 + 4 * i, 16, 1'b1);
      wr_valid = 1'b1; wr_addr = 15'(200 + i); wr_data = 8'(i);
      tick();
    end
    wr_valid = 1'b0; px(32, 16, 1'b1);
    check("pre_rst_ready", wr_ready, 1);
    #3;
    rst_n = 1'b0;
    log_q.delete();
    #1;
    check("mrst_ready", wr_ready, 1);
    check("mrst_we", mem_we, 0);
    check("mrst_addr", mem_addr, 0);
    check("mrst_rgb", rgb, 0);
    check("mrst_hs", hsync_out, 1);
    check("mrst_oob", oob_err, 0);
    px(700, 500, 1'b0);
    tick(); tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("mrst_nowrite", log_q.size(), 0);
    check("mrst_ready2", wr_ready, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
